// File: rtl/pb_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability counter and registered edge pulses.
// Build option: define PB_FALL_PULSE_EN to generate the pb_fall pulse register; otherwise pb_fall is tied low.
module pb_debounce #(
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb_in,
    output logic pb_clean,
    output logic pb_rise,
    output logic pb_fall
);

    localparam int unsigned CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    if (DB_CYCLES < 2 || DB_CYCLES > 65536) begin : g_bad_param
        $error("pb_debounce: DB_CYCLES must lie in 2..65536");
    end

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             mismatch;
    logic             settle;

    // settle fires on the DB_CYCLES-th consecutive disagreement, so cnt tops out at CNT_LAST
    assign mismatch = sync2 ^ pb_clean;
    assign settle   = mismatch && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pb_in;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            pb_clean <= 1'b0;
            pb_rise  <= 1'b0;
        end else begin
            if (!mismatch || settle) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (settle) begin
                pb_clean <= sync2;
            end
            pb_rise <= settle & sync2;
        end
    end

`ifdef PB_FALL_PULSE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pb_fall <= 1'b0;
        end else begin
            pb_fall <= settle & ~sync2;
        end
    end
`else
    assign pb_fall = 1'b0;
`endif

endmodule

// File: tb/tb_pb_debounce.sv
// Bench for pb_debounce (DB_CYCLES = 4): window-based reference model checked every cycle,
// plus hand-computed literal expectations for reset, glitch rejection, bounce and mid-count reset.
module tb_pb_debounce;

    localparam int DB = 4;
`ifdef PB_FALL_PULSE_EN
    localparam logic FALL_EN = 1'b1;
`else
    localparam logic FALL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pb_in = 1'b1;
    logic pb_clean, pb_rise, pb_fall;

    int checks = 0;
    int errors = 0;

    pb_debounce #(.DB_CYCLES(DB)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pb_in(pb_in),
        .pb_clean(pb_clean),
        .pb_rise(pb_rise),
        .pb_fall(pb_fall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: samp[i] is pb_in seen at edge i+1 after reset; the synchronized value after
    // edge e is samp[e-2]. The clean level flips at edge k when the synchronized values entering the
    // last DB edges all disagree with it and all of those edges came after the previous flip.
    bit samp[$];
    int k;
    int last_chg;
    logic m_clean, m_rise, m_fall;

    function automatic bit s2_after(int e);
        return (e >= 2) ? samp[e-2] : 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        bit flip;
        if (!rst_n) begin
            samp.delete();
            k = 0;
            last_chg = 0;
            m_clean = 1'b0;
            m_rise = 1'b0;
            m_fall = 1'b0;
        end else begin
            k++;
            flip = (k - DB >= last_chg);
            for (int j = k - DB + 1; j <= k; j++) begin
                if (flip && s2_after(j - 1) == m_clean) flip = 1'b0;
            end
            samp.push_back(pb_in);
            m_rise = flip && !m_clean;
            m_fall = flip && m_clean && FALL_EN;
            if (flip) begin
                m_clean = ~m_clean;
                last_chg = k;
            end
        end
    end

    always @(negedge clk) begin : compare
        chk("model_clean", pb_clean, m_clean);
        chk("model_rise", pb_rise, m_rise);
        chk("model_fall", pb_fall, m_fall);
        if (pb_rise && pb_fall) chk("rise_fall_exclusive", 1'b1, 1'b0);
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int rises;
        // Reset with button held: everything low during reset, rise after the 6th edge.
        #12;
        chk("rst_clean", pb_clean, 1'b0);
        chk("rst_rise", pb_rise, 1'b0);
        chk("rst_fall", pb_fall, 1'b0);
        #8 rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk); #1;
            chk($sformatf("rel_clean_e%0d", e), pb_clean, (e >= 6));
            chk($sformatf("rel_rise_e%0d", e), pb_rise, (e == 6));
        end
        chk("model_pin_clean_hi", m_clean, 1'b1);

        // Three-cycle low glitch must be rejected.
        @(negedge clk) pb_in = 1'b0;
        repeat (3) @(negedge clk);
        pb_in = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk); #1;
            chk("glitch_clean", pb_clean, 1'b1);
            chk("glitch_rise", pb_rise, 1'b0);
            chk("glitch_fall", pb_fall, 1'b0);
        end

        // Steady release: falls after the 6th edge.
        @(negedge clk) pb_in = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk); #1;
            chk($sformatf("fall_clean_e%0d", e), pb_clean, (e < 6));
            chk($sformatf("fall_pulse_e%0d", e), pb_fall, FALL_EN && (e == 6));
            chk($sformatf("fall_rise_e%0d", e), pb_rise, 1'b0);
        end
        chk("model_pin_clean_lo", m_clean, 1'b0);
        repeat (2) @(negedge clk);

        // Bounce 1,0,1,0,... for 8 cycles then hold 1; the held 1 is first sampled at edge 8.
        rises = 0;
        for (int c = 0; c < 8; c++) begin
            pb_in = (c % 2 == 0);
            @(posedge clk); #1;
            rises += int'(pb_rise);
            chk("bounce_clean", pb_clean, 1'b0);
            @(negedge clk);
        end
        pb_in = 1'b1;
        for (int e = 8; e <= 16; e++) begin
            @(posedge clk); #1;
            rises += int'(pb_rise);
            chk($sformatf("bounce_clean_e%0d", e), pb_clean, (e >= 13));
            chk($sformatf("bounce_rise_e%0d", e), pb_rise, (e == 13));
        end
        chk("bounce_one_rise", (rises == 1), 1'b1);

        // Reset mid-count while button held: clean clears at once, rises 6 edges after release.
        rst_n = 1'b0;
        #3;
        chk("pre_count_clear", pb_clean, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #2;
        chk("midrst_clean", pb_clean, 1'b0);
        chk("midrst_rise", pb_rise, 1'b0);
        chk("midrst_fall", pb_fall, 1'b0);
        #3 rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            chk($sformatf("midrst_clean_e%0d", e), pb_clean, (e >= 6));
            chk($sformatf("midrst_rise_e%0d", e), pb_rise, (e == 6));
        end

        // Second release to exercise the fall path once more.
        @(negedge clk) pb_in = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            chk($sformatf("fall2_clean_e%0d", e), pb_clean, (e < 6));
            chk($sformatf("fall2_pulse_e%0d", e), pb_fall, FALL_EN && (e == 6));
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pb_debounce.md
PB_DEBOUNCE -- requirements
Module: pb_debounce

Interface
REQ-001 Parameter DB_CYCLES, default 16: consecutive mismatching clock cycles required before pb_clean changes; legal range 2..65536.
REQ-002 clk  input  1  the one clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 pb_in  input  1  raw push-button level, asynchronous to clk, may bounce.
REQ-005 pb_clean  output  1  synchronized, debounced level; drives the d input of the downstream flop.
REQ-006 pb_rise  output  1  single-cycle pulse, high in the first cycle pb_clean is 1 after being 0.
REQ-007 pb_fall  output  1  single-cycle pulse on pb_clean 1->0 (see Configuration).

Function
REQ-008 Synchronizer: pb_in SHALL pass through exactly two flops (sync1, sync2) before any other logic uses it.
REQ-009 Stability counter width SHALL be $clog2(DB_CYCLES) bits.
REQ-010 On an edge where sync2 == pb_clean, the counter SHALL clear to 0.
REQ-011 On an edge where sync2 != pb_clean and counter < DB_CYCLES-1, the counter SHALL increment by 1.
REQ-012 On an edge where sync2 != pb_clean and counter == DB_CYCLES-1, pb_clean SHALL load sync2 and the counter SHALL clear to 0.
REQ-013 Latency: pb_in changed before edge N and held stable -> pb_clean changes after edge N+1+DB_CYCLES.
REQ-014 A bounce returning sync2 to pb_clean before DB_CYCLES consecutive mismatches SHALL restart the count from 0 with no output change.
REQ-015 The counter SHALL never wrap; it never exceeds DB_CYCLES-1.
REQ-016 pb_rise SHALL be registered: high exactly one cycle, coincident with the first high cycle of pb_clean; never high otherwise.
REQ-017 pb_rise and pb_fall SHALL never be high in the same cycle.
REQ-018 pb_clean SHALL be glitch-free (flop output, no combinational path from pb_in).

Reset
REQ-019 rst_n low SHALL immediately clear sync1, sync2, counter, pb_clean, pb_rise, pb_fall to 0, independent of clk.
REQ-020 Reset asserted mid-count SHALL discard the partial count; after release, counting restarts from 0 against pb_clean = 0.
REQ-021 If pb_in is 1 at reset release, pb_clean SHALL rise after the normal REQ-013 latency and produce one pb_rise pulse.

Configuration
REQ-022 Macro PB_FALL_PULSE_EN defined: pb_fall SHALL be a registered pulse high exactly one cycle, coincident with the first low cycle of pb_clean after being 1.
REQ-023 Macro PB_FALL_PULSE_EN undefined: pb_fall SHALL be tied to constant 0 and its pulse register SHALL not be instantiated; all other behaviour unchanged.

Verification (DB_CYCLES = 4, 10-unit clock period)
REQ-024 rst_n low 20 units, pb_in = 1 throughout -> all outputs 0 during reset; after release, pb_clean rises after 6th edge, pb_rise high exactly one cycle.
REQ-025 pb_clean = 1, pb_in pulses low for 3 cycles then returns high -> pb_clean stays 1, no pb_rise/pb_fall pulse.
REQ-026 pb_in bounces 1,0,1,0 per cycle for 8 cycles then holds 1 -> pb_clean rises exactly once, 6 edges after the final stable 1 is sampled.
REQ-027 pb_in held 1, rst_n pulsed low for 5 units between edges 4 and 5 -> outputs clear immediately; pb_clean rises 6 edges after release edge, not earlier.
REQ-028 PB_FALL_PULSE_EN defined, pb_clean = 1, pb_in held 0 -> pb_clean falls after 6th edge, pb_fall high one cycle; macro undefined -> pb_fall stays 0 for whole run.
